// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable, pausable 4-bit down-counter with a clock prescaler.
//   Each count step takes PRESCALE enabled clk cycles (one second on the
//   board clock). The count floors at zero instead of wrapping.
//
// Parameters:
//   PRESCALE    enabled clk cycles per count step (>= 1)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   timer_en    count enable; low pauses both prescaler and count
//   timer_load  synchronous load of timer_init; overrides timer_en
//   timer_init  load value in seconds (0-15)
//   timer_out   registered remaining count
//   tick        one-cycle pulse on every prescaler wrap
//   expired     one-cycle pulse when the count steps from 1 to 0
module countdown_timer #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_en,
  input  logic       timer_load,
  input  logic [3:0] timer_init,
  output logic [3:0] timer_out,
  output logic       tick,
  output logic       expired
);

  // A PRESCALE of 1 still needs a 1-bit counter; it simply stays at 0.
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else if (timer_load) begin
      count   <= timer_init;
      pre_cnt <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else if (timer_en) begin
      if (pre_cnt == PRE_MAX) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
        expired <= (count == 4'd1);
        if (count != 4'd0) begin
          count <= count - 4'd1;
        end
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
        tick    <= 1'b0;
        expired <= 1'b0;
      end
    end else begin
      tick    <= 1'b0;
      expired <= 1'b0;
    end
  end

  assign timer_out = count;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed bench for countdown_timer with PRESCALE=4, plus a PRESCALE=1
//   instance sharing the same stimulus.
module tb_countdown_timer;

  localparam int unsigned P = 4;

  logic       clk;
  logic       rst;
  logic       timer_en;
  logic       timer_load;
  logic [3:0] timer_init;
  logic [3:0] timer_out;
  logic       tick;
  logic       expired;
  logic [3:0] timer_out1;
  logic       tick1;
  logic       expired1;

  countdown_timer #(.PRESCALE(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .timer_en   (timer_en),
    .timer_load (timer_load),
    .timer_init (timer_init),
    .timer_out  (timer_out),
    .tick       (tick),
    .expired    (expired)
  );

  countdown_timer #(.PRESCALE(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .timer_en   (timer_en),
    .timer_load (timer_load),
    .timer_init (timer_init),
    .timer_out  (timer_out1),
    .tick       (tick1),
    .expired    (expired1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] out;
    logic       tk;
    logic       ex;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference state for the PRESCALE=4 instance.
  int m_pre = 0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle: predict the post-edge outputs, push them, then pop and
  // compare after the edge.
  task automatic cycle(input logic en, input logic ld, input logic [3:0] init);
    exp_t e;
    exp_t got;
    timer_en   = en;
    timer_load = ld;
    timer_init = init;
    e.tk = 1'b0;
    e.ex = 1'b0;
    if (ld) begin
      m_cnt = int'(init);
      m_pre = 0;
    end else if (en) begin
      if (m_pre == int'(P) - 1) begin
        m_pre = 0;
        e.tk  = 1'b1;
        e.ex  = (m_cnt == 1);
        if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    e.out = 4'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("sb_timer_out", 32'(timer_out), 32'(got.out));
    chk("sb_tick", 32'(tick), 32'(got.tk));
    chk("sb_expired", 32'(expired), 32'(got.ex));
  endtask

  initial begin
    rst        = 1'b1;
    timer_en   = 1'b0;
    timer_load = 1'b0;
    timer_init = 4'd0;
    #12;
    chk("reset_out", 32'(timer_out), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_expired", 32'(expired), 32'd0);
    rst = 1'b0;
    m_pre = 0;
    m_cnt = 0;

    // 1: idle with enable, no load
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0, 4'd0);
      if (i == 3) chk("idle_tick_off", 32'(tick), 32'd0);
      if (i == 4) chk("idle_tick_on", 32'(tick), 32'd1);
      if (i == 1) chk("p1_idle_tick", 32'(tick1), 32'd1);
    end
    chk("idle_out", 32'(timer_out), 32'd0);

    // 2: basic countdown from 5
    cycle(1'b1, 1'b1, 4'd5);
    chk("load5_out", 32'(timer_out), 32'd5);
    chk("p1_load5_out", 32'(timer_out1), 32'd5);
    for (int i = 1; i <= 19; i++) begin
      cycle(1'b1, 1'b0, 4'd0);
      if (i == 1) chk("p1_step_out", 32'(timer_out1), 32'd4);
      if (i == 3) chk("first_step_pending", 32'(timer_out), 32'd5);
      if (i == 4) chk("first_step", 32'(timer_out), 32'd4);
      if (i == 5) chk("p1_expired", 32'(expired1), 32'd1);
      if (i == 6) chk("p1_floor", 32'(timer_out1), 32'd0);
      if (i == 6) chk("p1_expired_once", 32'(expired1), 32'd0);
    end
    chk("cd_before_zero", 32'(timer_out), 32'd1);
    chk("cd_no_early_exp", 32'(expired), 32'd0);
    cycle(1'b1, 1'b0, 4'd0);
    chk("cd_zero_at_20", 32'(timer_out), 32'd0);
    chk("cd_expired_at_20", 32'(expired), 32'd1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("cd_floor", 32'(timer_out), 32'd0);

    // 3: pause mid-step
    cycle(1'b1, 1'b1, 4'd3);
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'd0);
    chk("pause_hold", 32'(timer_out), 32'd3);
    cycle(1'b1, 1'b0, 4'd0);
    chk("resume_1", 32'(timer_out), 32'd3);
    cycle(1'b1, 1'b0, 4'd0);
    chk("resume_2", 32'(timer_out), 32'd2);
    chk("resume_2_tick", 32'(tick), 32'd1);

    // 4: reload mid-count colliding with a wrap
    cycle(1'b1, 1'b1, 4'd10);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("reload_at7", 32'(timer_out), 32'd7);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("reload_pre3", 32'(timer_out), 32'd7);
    cycle(1'b1, 1'b1, 4'd2);
    chk("collide_out", 32'(timer_out), 32'd2);
    chk("collide_tick", 32'(tick), 32'd0);
    chk("collide_expired", 32'(expired), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("reload_step1", 32'(timer_out), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("reload_step0", 32'(timer_out), 32'd0);
    chk("reload_expired", 32'(expired), 32'd1);

    // 5: load of zero, then async reset mid-count
    cycle(1'b1, 1'b1, 4'd0);
    chk("load0_out", 32'(timer_out), 32'd0);
    chk("load0_expired", 32'(expired), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 4'd15);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("pre_rst_out", 32'(timer_out), 32'd13);
    cycle(1'b1, 1'b0, 4'd0);
    chk("pre_rst_out12", 32'(timer_out), 32'd12);
    chk("pre_rst_tick", 32'(tick), 32'd1);
    timer_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(timer_out), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_expired", 32'(expired), 32'd0);
    #2;
    rst = 1'b0;
    m_pre = 0;
    m_cnt = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("post_rst_idle", 32'(timer_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Seconds-resolution countdown timer feeding `traffic_light_controller`. It accepts the controller's `timer_en`, `timer_load` and `timer_init` commands and returns the remaining count on `timer_out`. The controller uses that count to sequence the walk, green and yellow intervals. An internal prescaler divides `clk` down to one count step per `PRESCALE` enabled cycles (one second on the board clock). Single-cycle `tick` and `expired` pulses are provided for debug LEDs and for the bench.

## Interface
Parameters:
- `PRESCALE`, default 50_000_000: enabled `clk` cycles per count step; legal range ≥ 1. Benches use 4.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  reset, asynchronous, active-high
- `timer_en`  input  1  count enable; 0 pauses the prescaler and the count
- `timer_load`  input  1  synchronous load of `timer_init`; has priority over `timer_en`
- `timer_init`  input  4  load value, in seconds (0–15)
- `timer_out`  output  4  registered remaining count
- `tick`  output  1  registered one-cycle pulse on every prescaler wrap
- `expired`  output  1  registered one-cycle pulse when the count steps from 1 to 0

Reset is `rst`, asynchronous, active-high. The clock is `clk`.

## Operation
- **Internal state**
  - `pre_cnt`: width `max(1, clog2(PRESCALE))`, counts 0 to `PRESCALE-1`.
  - `count`: 4 bits, drives `timer_out`.
- **Reset** (async, effective immediately): `pre_cnt`=0, `count`=0, so `timer_out`=0. `tick`=0, `expired`=0.
- **Load** (`timer_load`=1 at a rising edge, any `timer_en`):
  - `count` ← `timer_init`, `pre_cnt` ← 0.
  - `tick` and `expired` are 0 in the following cycle.
- **Count** (`timer_load`=0, `timer_en`=1):
  - If `pre_cnt` = `PRESCALE-1`: `pre_cnt` ← 0 and `tick` ← 1.
    - If `count` ≠ 0: `count` ← `count`−1.
    - If `count` = 1, `expired` ← 1 in the same update.
  - Otherwise: `pre_cnt` ← `pre_cnt`+1, `tick` ← 0.
- **Pause** (`timer_load`=0, `timer_en`=0): `pre_cnt` and `count` hold. `tick` and `expired` are 0.
- **Zero floor**: at `count`=0 with `timer_en`=1, the prescaler keeps wrapping and `tick` keeps pulsing. `count` stays 0 and never wraps to 15. `expired` is not reasserted.
- **Load of 0**: `timer_out` becomes 0 immediately. No `expired` pulse.
- **`PRESCALE`=1**: `pre_cnt` is constantly 0. Every enabled cycle is a step and `tick` stays high while enabled.
- The block has no other state. It is purely a loadable, pausable down-counter plus prescaler.

## Timing
- **Load latency**: `timer_out` shows `timer_init` in the cycle after the edge where `timer_load`=1.
- **First step**: after a load, the first decrement happens on the `PRESCALE`-th enabled rising edge. Paused cycles are not counted.
- **Subsequent steps**: one every `PRESCALE` enabled edges.
- **Total duration**: a load of N with continuous enable reaches 0 exactly N×`PRESCALE` edges after the load edge.
- **Pulse alignment**: `tick`, `expired` and the `timer_out` decrement all change on the same edge. Each pulse lasts exactly one cycle.
- **Simultaneous `timer_load` and wrap**: the load wins. No `tick`, no decrement, no `expired`.
- **Load during an active count**: restarts cleanly. Partial prescaler progress is discarded.
- **Pause mid-step**: resuming continues from the held `pre_cnt`, so the step period is preserved across the pause.
- **`rst` mid-count**: all outputs clear asynchronously. After release the block idles at 0 until the next load.

## Test plan
1. **Reset then idle**: `PRESCALE`=4, assert `rst`, release, hold `timer_en`=1 with no load for 20 cycles.
   - Required: `timer_out`=0 throughout, `tick` pulses every 4 cycles, `expired` never asserts.
2. **Basic countdown**: load 5, then `timer_en`=1.
   - Required: `timer_out` goes 5,4,3,2,1,0 with steps 4 edges apart.
   - Required: 0 is reached 20 edges after the load edge, `expired` pulses once on that edge, and `timer_out` holds 0 for 12 more cycles.
3. **Pause**: load 3, enable for 2 cycles, disable for 10 cycles, re-enable.
   - Required: the first decrement occurs 2 enabled cycles after re-enable, and `timer_out`=3 is held during the pause.
4. **Reload mid-count and load/wrap collision**: load 10, count to 7, then assert `timer_load` with `timer_init`=2 on the edge where `pre_cnt`=3.
   - Required: `timer_out`=2, no `tick` and no decrement that cycle, then 2→1→0 at 4-cycle spacing.
5. **Load of 0 and async reset mid-count**:
   - Load 0: `timer_out`=0 next cycle, no `expired`.
   - Load 15, enable, pulse `rst` between clock edges at `timer_out`=12: `timer_out`, `tick` and `expired` read 0 before the next edge.
6. **Controller integration**: connect to `traffic_light_controller` with `PRESCALE`=4 and `ped`=1 after reset.
   - Required: `light_ped`=`PED_BOTH` for 15×4 enabled cycles, then the controller advances when `timer_out`=0.
